// File: rtl/risc_eunit_if.sv
// Bus bundle for risc_eunit: instruction/enable in, loader and debug ports, writeback outputs.
// The fetch side (master) drives ir/en/loader/debug address; the execution unit (slave) returns results.
interface risc_eunit_if #(
  parameter int DW = 8
);
  logic [12:0]   ir;
  logic          en;
  logic          init_we;
  logic [2:0]    init_addr;
  logic [DW-1:0] init_data;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [DW-1:0] result;
  logic [2:0]    wb_rd;
  logic          wb_valid;
  logic          flag_z;
  logic          flag_c;
  logic          flag_n;
  logic          illegal;

  modport master (
    output ir, en, init_we, init_addr, init_data, dbg_addr,
    input  dbg_data, result, wb_rd, wb_valid, flag_z, flag_c, flag_n, illegal
  );

  modport slave (
    input  ir, en, init_we, init_addr, init_data, dbg_addr,
    output dbg_data, result, wb_rd, wb_valid, flag_z, flag_c, flag_n, illegal
  );
endinterface

// File: rtl/risc_eunit.sv
// Two-stage execution unit: decode/operand fetch, then ALU execute and register writeback.
// Handshake: en qualifies every edge of both stages (no back-pressure); wb_valid/illegal are one-cycle pulses.
module risc_eunit #(
  parameter int DW = 8
) (
  input logic        clk,
  input logic        rst_n,
  risc_eunit_if.slave bus
);
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_NEG = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_SHL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  localparam logic [3:0] OP_ROL = 4'd13;

  logic [DW-1:0] rf [8];

  logic          s1_valid;
  logic [3:0]    s1_op;
  logic [2:0]    s1_rd;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;

  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_wr;
  logic          alu_ill;
  logic          wb_fire;

  logic [DW-1:0] result_q;
  logic [2:0]    wb_rd_q;
  logic          wb_valid_q;
  logic          illegal_q;
  logic          z_q, c_q, n_q;

  logic [2:0]    rs1, rs2;
  logic [DW-1:0] op_a, op_b;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    alu_ill = 1'b0;
    case (s1_op)
      OP_ADD: {alu_c, alu_res} = {1'b0, s1_a} + {1'b0, s1_b};
      OP_SUB: begin alu_res = s1_a - s1_b; alu_c = (s1_b > s1_a); end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_INC: {alu_c, alu_res} = {1'b0, s1_a} + (DW+1)'(1);
      OP_DEC: begin alu_res = s1_a - DW'(1); alu_c = (s1_a == '0); end
      OP_NOT: alu_res = ~s1_a;
      OP_NEG: begin alu_res = '0 - s1_a; alu_c = |s1_a; end
      OP_SHR: begin alu_res = {1'b0, s1_a[DW-1:1]}; alu_c = s1_a[0]; end
      OP_SHL: begin alu_res = {s1_a[DW-2:0], 1'b0}; alu_c = s1_a[DW-1]; end
      OP_ROR: begin alu_res = {s1_a[0], s1_a[DW-1:1]}; alu_c = s1_a[0]; end
      OP_ROL: begin alu_res = {s1_a[DW-2:0], s1_a[DW-1]}; alu_c = s1_a[DW-1]; end
      OP_NOP: alu_wr = 1'b0;
      default: begin alu_wr = 1'b0; alu_ill = 1'b1; end
    endcase
  end

  assign wb_fire = bus.en & s1_valid & alu_wr;
  assign rs1     = bus.ir[5:3];
  assign rs2     = bus.ir[2:0];

  // Forward the result being written this edge so back-to-back dependents see it.
  assign op_a = (wb_fire && (s1_rd == rs1)) ? alu_res : rf[rs1];
  assign op_b = (wb_fire && (s1_rd == rs2)) ? alu_res : rf[rs2];

  // Writeback is the later assignment, so it wins a same-register loader collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (bus.init_we) rf[bus.init_addr] <= bus.init_data;
      if (wb_fire)     rf[s1_rd]         <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_NOP;
      s1_rd      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      result_q   <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      wb_valid_q <= wb_fire;
      illegal_q  <= bus.en & s1_valid & alu_ill;
      if (bus.en) begin
        s1_valid <= 1'b1;
        s1_op    <= bus.ir[12:9];
        s1_rd    <= bus.ir[8:6];
        s1_a     <= op_a;
        s1_b     <= op_b;
        if (s1_valid && alu_wr) begin
          result_q <= alu_res;
          wb_rd_q  <= s1_rd;
          z_q      <= (alu_res == '0);
          c_q      <= alu_c;
          n_q      <= alu_res[DW-1];
        end
      end
    end
  end

  assign bus.dbg_data = rf[bus.dbg_addr];
  assign bus.result   = result_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.illegal  = illegal_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;
  assign bus.flag_n   = n_q;
endmodule

// File: doc/risc_eunit.md
RISC_EUNIT -- requirements
Module: risc_eunit

Interface
REQ-001 The block SHALL have parameter DW, default 8, the register and ALU data width.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ir  input  13  instruction from the fetch unit: opcode [12:9], rd [8:6], rs1 [5:3], rs2 [2:0].
REQ-005 en  input  1  advance enable; 0 SHALL freeze both pipeline stages.
REQ-006 init_we  input  1  loader write strobe into the register file.
REQ-007 init_addr  input  3  loader register index.
REQ-008 init_data  input  DW  loader write data.
REQ-009 dbg_addr  input  3  debug read index.
REQ-010 dbg_data  output  DW  combinational read of rf[dbg_addr].
REQ-011 result  output  DW  last written-back ALU result.
REQ-012 wb_rd  output  3  destination of the last writeback.
REQ-013 wb_valid  output  1  one-cycle pulse per writeback.
REQ-014 flag_z, flag_c, flag_n  output  1 each  zero, carry/borrow, negative status.
REQ-015 illegal  output  1  one-cycle pulse when opcode 14 or 15 reaches stage 2.

Function
REQ-016 Opcode map SHALL be: 0 nop, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 inc, 7 dec, 8 not, 9 neg, 10 shr, 11 shl, 12 ror, 13 rol, 14-15 illegal.
REQ-017 Binary ops SHALL compute rd = rs1 op rs2; unary ops (6-13) SHALL use rs1 only and ignore rs2.
REQ-018 Register file SHALL be 8 x DW flip-flops, r0 writable like any other register.
REQ-019 Stage 1 (decode), on each en=1 edge: latch opcode, rd, operand A = rs1 value, operand B = rs2 value, s1_valid=1.
REQ-020 Stage 2 (execute/writeback), on each en=1 edge with s1_valid: compute ALU, write rf[rd], update flags, drive result/wb_rd, pulse wb_valid.
REQ-021 Latency SHALL be 2 clocks: ir sampled at edge t, rf[rd]/flags visible after edge t+1.
REQ-022 Bypass: when stage 2 writes register X on the same edge stage 1 reads X, stage 1 SHALL latch the new ALU result, not the stale rf value.
REQ-023 add/inc SHALL set C to carry out of bit DW-1; sub/dec/neg SHALL set C to borrow (1 when the unsigned subtrahend exceeds the minuend).
REQ-024 shr/shl SHALL shift by 1 with zero fill, C = bit shifted out; ror/rol SHALL rotate by 1, C = bit rotated across.
REQ-025 and/or/xor/not SHALL clear C.
REQ-026 Every op 1-13 SHALL set Z = (result==0) and N = result[DW-1]; arithmetic SHALL wrap modulo 2^DW.
REQ-027 nop and illegal SHALL not write rf, SHALL leave flags and result unchanged, and SHALL not pulse wb_valid; illegal SHALL pulse illegal.
REQ-028 en=0 SHALL hold all stage registers, flags and outputs; wb_valid and illegal SHALL be 0 while en=0.
REQ-029 init_we SHALL write rf[init_addr]=init_data on the edge regardless of en; a same-edge collision with a writeback to the same register SHALL resolve with the writeback winning.

Reset
REQ-030 rst_n=0 SHALL immediately clear all 8 registers, s1_valid, opcode latch, result, wb_rd, wb_valid, illegal, and all flags to 0.
REQ-031 Reset mid-operation SHALL discard in-flight instructions with no writeback; the first instruction sampled after release SHALL complete 2 clocks later.

Verification
REQ-032 Preload r1=0x05, r2=0x03; ir=0x0211 (add r0,r2,r1) -> r0=0x08, Z=0 C=0 N=0, wb_rd=0, one wb_valid pulse 2 clocks later.
REQ-033 r1=0x03, r2=0x05; ir=0x04CA (sub r3,r1,r2) -> r3=0xFE, C=1, N=1, Z=0.
REQ-034 r4=0xFF; ir=0x0D20 (inc r4) on two consecutive cycles -> after first r4=0x00, Z=1, C=1; after second r4=0x01, Z=0, C=0 (bypass exercised).
REQ-035 r6=0x81; ir=0x1B70 (rol r5,r6) -> r5=0x03, C=1; ir=0x1570 (shr r5,r6) -> r5=0x40, C=1.
REQ-036 ir=0x1E00 -> illegal pulses once, no register change, flags unchanged; ir=0x0000 -> no pulse and no change.
REQ-037 ir=0x0211 then rst_n=0 one clock later for 5 ns -> no wb_valid, all registers and flags 0; the next add after release completes normally.
